// File: rtl/uart_bus_master.sv
// UART command bridge: turns RX FIFO command bytes into single slot-bus reads/writes and answers over the TX FIFO.
// Optional inter-byte timeout on write data is compiled in with `define UART_BUS_MASTER_TIMEOUT_EN.
module uart_bus_master #(
  parameter int ADDR_W      = 5,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_empty,
  output logic              rd_uart,
  input  logic              tx_full,
  output logic              wr_uart,
  output logic [7:0]        w_data,
  output logic              cs,
  output logic              read,
  output logic              write,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] rd_data,
  output logic              busy
);

  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;

  typedef enum logic [2:0] {IDLE, WDATA, WBUS, RBUS, RESP} state_t;

  state_t              state, state_nxt;
  logic                pop_q;
  logic [1:0]          byte_cnt;
  logic [DATA_W-9:0]   wbuf;
  logic [DATA_W-1:0]   tx_sreg;
  logic [2:0]          tx_left;
  logic                cmd_bad;
  logic                timeout;

  assign cmd_bad = (rx_data[6:5] != 2'b00);
  assign w_data  = tx_sreg[7:0];
  assign busy    = !reset && (state != IDLE);

`ifdef UART_BUS_MASTER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC) + 1;
  logic [TMO_W-1:0] tmo_cnt;

  always_ff @(posedge clk) begin
    if (reset || state != WDATA || rd_uart)
      tmo_cnt <= '0;
    else
      tmo_cnt <= tmo_cnt + 1'b1;
  end

  assign timeout = (state == WDATA) && !rd_uart && (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Strobes are decoded from state and gated by reset so nothing fires while reset is held.
  always_comb begin
    state_nxt = state;
    rd_uart   = 1'b0;
    wr_uart   = 1'b0;
    cs        = 1'b0;
    read      = 1'b0;
    write     = 1'b0;
    if (!reset) begin
      case (state)
        IDLE: begin
          rd_uart = !rx_empty && !pop_q;
          if (rd_uart) begin
            if (cmd_bad)         state_nxt = RESP;
            else if (rx_data[7]) state_nxt = WDATA;
            else                 state_nxt = RBUS;
          end
        end
        WDATA: begin
          rd_uart = !rx_empty && !pop_q;
          if (rd_uart && byte_cnt == 2'd3) state_nxt = WBUS;
          else if (timeout)                state_nxt = RESP;
        end
        WBUS: begin
          cs        = 1'b1;
          write     = 1'b1;
          state_nxt = RESP;
        end
        RBUS: begin
          cs        = 1'b1;
          read      = 1'b1;
          state_nxt = RESP;
        end
        RESP: begin
          wr_uart = !tx_full;
          if (wr_uart && tx_left == 3'd1) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pop_q    <= 1'b0;
      addr     <= '0;
      wr_data  <= '0;
      wbuf     <= '0;
      byte_cnt <= '0;
      tx_sreg  <= '0;
      tx_left  <= '0;
    end else begin
      pop_q <= rd_uart;
      case (state)
        IDLE: begin
          if (rd_uart) begin
            if (cmd_bad) begin
              tx_sreg <= {{(DATA_W-8){1'b0}}, NAK};
              tx_left <= 3'd1;
            end else begin
              addr     <= rx_data[ADDR_W-1:0];
              byte_cnt <= '0;
            end
          end
        end
        WDATA: begin
          if (rd_uart) begin
            // Bytes enter at the top so the first one ends up in the low lane.
            byte_cnt <= byte_cnt + 2'd1;
            wbuf     <= {rx_data, wbuf[DATA_W-9:8]};
            if (byte_cnt == 2'd3) wr_data <= {rx_data, wbuf};
          end else if (timeout) begin
            tx_sreg <= {{(DATA_W-8){1'b0}}, NAK};
            tx_left <= 3'd1;
          end
        end
        WBUS: begin
          tx_sreg <= {{(DATA_W-8){1'b0}}, ACK};
          tx_left <= 3'd1;
        end
        RBUS: begin
          tx_sreg <= rd_data;
          tx_left <= 3'd4;
        end
        RESP: begin
          if (wr_uart) begin
            tx_sreg <= {8'h00, tx_sreg[DATA_W-1:8]};
            tx_left <= tx_left - 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_bus_master.sv
// Scoreboarded bench for uart_bus_master: models the RX FIFO, queues expected bus cycles and TX bytes.
module tb_uart_bus_master;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [4:0]  a;
    logic [31:0] d;
  } bus_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_empty;
  logic        rd_uart;
  logic        tx_full;
  logic        wr_uart;
  logic [7:0]  w_data;
  logic        cs, read, write;
  logic [4:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] rx_q[$];
  logic [7:0] exp_tx[$];
  bus_t       exp_bus[$];

  uart_bus_master #(.ADDR_W(5), .DATA_W(32), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_empty(rx_empty), .rd_uart(rd_uart),
    .tx_full(tx_full), .wr_uart(wr_uart), .w_data(w_data), .cs(cs), .read(read), .write(write),
    .addr(addr), .wr_data(wr_data), .rd_data(rd_data), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic void rx_refresh();
    rx_empty = (rx_q.size() == 0);
    rx_data  = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
  endfunction

  // Monitor: samples on the falling edge, applies pops just after the rising edge.
  int   cyc = 0;
  int   last_pop = -10;
  int   resp_left = 0;
  logic pend = 1'b0;
  logic rd_prev = 1'b0;
  logic [7:0] eb;
  bus_t ebus;

  always begin
    @(negedge clk);
    cyc++;
    pend = rd_uart;
    if (reset) begin
      resp_left = 0;
    end else begin
      if (rd_uart) begin
        checks++;
        if (rd_prev || rx_empty) begin
          errors++;
          $display("FAIL rd_uart_rule: rd_prev=%0b rx_empty=%0b, required 0/0", rd_prev, rx_empty);
        end
        last_pop = cyc;
      end
      if (tx_full && busy) begin
        checks++;
        if (wr_uart !== 1'b0) begin
          errors++;
          $display("FAIL stall_push: wr_uart=%0b while tx_full, required 0", wr_uart);
        end
      end else if (resp_left > 0) begin
        checks++;
        if (wr_uart !== 1'b1) begin
          errors++;
          $display("FAIL resp_gap: wr_uart=%0b, required 1 (%0d bytes pending)", wr_uart, resp_left);
        end
      end
      if (wr_uart) begin
        checks++;
        if (resp_left > 0) resp_left--;
        if (exp_tx.size() == 0) begin
          errors++;
          $display("FAIL tx_unexpected: got byte %02h, required none", w_data);
        end else begin
          eb = exp_tx.pop_front();
          if (w_data !== eb) begin
            errors++;
            $display("FAIL tx_byte: got %02h, required %02h", w_data, eb);
          end
        end
      end
      if (cs || read || write) begin
        checks++;
        if (exp_bus.size() == 0) begin
          errors++;
          $display("FAIL bus_unexpected: cs=%0b rd=%0b wr=%0b addr=%02h, required no cycle", cs, read, write, addr);
        end else begin
          ebus = exp_bus.pop_front();
          if (cs !== 1'b1 || read !== ebus.rd || write !== ebus.wr || addr !== ebus.a ||
              (ebus.wr && wr_data !== ebus.d)) begin
            errors++;
            $display("FAIL bus_cycle: cs=%0b rd=%0b wr=%0b addr=%02h data=%08h, required 1 %0b %0b %02h %08h",
                     cs, read, write, addr, wr_data, ebus.rd, ebus.wr, ebus.a, ebus.d);
          end
        end
        checks++;
        if (cyc != last_pop + 1) begin
          errors++;
          $display("FAIL bus_latency: strobe %0d cycles after pop, required 1", cyc - last_pop);
        end
        resp_left = read ? 4 : 1;
      end
    end
    rd_prev = rd_uart;
    @(posedge clk);
    #1;
    if (pend) void'(rx_q.pop_front());
    rx_refresh();
  end

  task automatic send(input logic [7:0] b);
    @(posedge clk);
    #2;
    rx_q.push_back(b);
    rx_refresh();
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (n < budget && (busy || rx_q.size() != 0 || exp_tx.size() != 0 || exp_bus.size() != 0)) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    checks++;
    if (busy || rx_q.size() != 0 || exp_tx.size() != 0 || exp_bus.size() != 0) begin
      errors++;
      $display("FAIL idle_timeout: busy=%0b rx=%0d tx_pend=%0d bus_pend=%0d, required all 0",
               busy, rx_q.size(), exp_tx.size(), exp_bus.size());
    end
  endtask

  task automatic expect_read(input logic [4:0] a, input logic [31:0] d);
    exp_bus.push_back('{rd: 1'b1, wr: 1'b0, a: a, d: 32'h0});
    for (int i = 0; i < 4; i++) exp_tx.push_back(8'(d >> (8 * i)));
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({cs, read, write, rd_uart, wr_uart, busy} !== 6'b0 || addr !== 5'h0 || wr_data !== 32'h0 || w_data !== 8'h0) begin
      errors++;
      $display("FAIL reset_outputs: strobes=%06b addr=%02h wd=%08h w_data=%02h, required all 0",
               {cs, read, write, rd_uart, wr_uart, busy}, addr, wr_data, w_data);
    end
    @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || rd_uart !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: busy=%0b rd_uart=%0b, required 0/0", busy, rd_uart);
    end
  endtask

  task automatic test_write();
    exp_bus.push_back('{rd: 1'b0, wr: 1'b1, a: 5'h03, d: 32'h12345678});
    exp_tx.push_back(8'h06);
    send(8'h83); send(8'h78); send(8'h56); send(8'h34); send(8'h12);
    wait_idle(60);
    checks++;
    if (addr !== 5'h03 || wr_data !== 32'h12345678) begin
      errors++;
      $display("FAIL write_hold: addr=%02h wd=%08h, required 03 12345678", addr, wr_data);
    end
  endtask

  task automatic test_read();
    rd_data = 32'hDEADBEEF;
    expect_read(5'h05, 32'hDEADBEEF);
    send(8'h05);
    wait_idle(40);
  endtask

  task automatic test_backpressure();
    rd_data = 32'hCAFE1234;
    expect_read(5'h05, 32'hCAFE1234);
    @(posedge clk);
    #2 tx_full = 1'b1;
    send(8'h05);
    repeat (13) @(posedge clk);
    #2;
    checks++;
    if (exp_tx.size() != 4 || busy !== 1'b1) begin
      errors++;
      $display("FAIL stall_hold: pending=%0d busy=%0b, required 4 1", exp_tx.size(), busy);
    end
    tx_full = 1'b0;
    wait_idle(40);
  endtask

  task automatic test_bad_cmd();
    exp_tx.push_back(8'h15);
    send(8'h40);
    wait_idle(40);
    rd_data = 32'h0BADF00D;
    expect_read(5'h01, 32'h0BADF00D);
    send(8'h01);
    wait_idle(40);
  endtask

  task automatic test_reset_mid_write();
    int n;
    send(8'h82); send(8'h11); send(8'h22);
    n = 0;
    while (rx_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({cs, read, write, rd_uart, wr_uart, busy} !== 6'b0) begin
      errors++;
      $display("FAIL reset_mid_strobes: %06b, required 000000", {cs, read, write, rd_uart, wr_uart, busy});
    end
    @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || addr !== 5'h0 || wr_data !== 32'h0 || w_data !== 8'h0 || cs !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_state: busy=%0b addr=%02h wd=%08h w_data=%02h cs=%0b, required 0",
               busy, addr, wr_data, w_data, cs);
    end
    rd_data = 32'h76543210;
    expect_read(5'h02, 32'h76543210);
    send(8'h02);
    wait_idle(40);
  endtask

  task automatic test_timeout();
`ifdef UART_BUS_MASTER_TIMEOUT_EN
    exp_tx.push_back(8'h15);
    send(8'h81); send(8'hAA);
    repeat (20) @(posedge clk);
    wait_idle(40);
    checks++;
    if (wr_data !== 32'h0) begin
      errors++;
      $display("FAIL timeout_discard: wd=%08h, required 00000000", wr_data);
    end
`else
    send(8'h81); send(8'hAA);
    repeat (20) @(posedge clk);
    #2;
    checks++;
    if (busy !== 1'b1 || exp_tx.size() != 0) begin
      errors++;
      $display("FAIL no_timeout_wait: busy=%0b, required 1", busy);
    end
    exp_bus.push_back('{rd: 1'b0, wr: 1'b1, a: 5'h01, d: 32'hDDCCBBAA});
    exp_tx.push_back(8'h06);
    send(8'hBB); send(8'hCC); send(8'hDD);
    wait_idle(40);
`endif
  endtask

  task automatic test_back_to_back();
    rd_data = 32'h89ABCDEF;
    exp_bus.push_back('{rd: 1'b0, wr: 1'b1, a: 5'h1F, d: 32'h04030201});
    exp_tx.push_back(8'h06);
    expect_read(5'h1F, 32'h89ABCDEF);
    send(8'h9F); send(8'h01); send(8'h02); send(8'h03); send(8'h04); send(8'h1F);
    wait_idle(100);
    checks++;
    if (wr_data !== 32'h04030201 || addr !== 5'h1F) begin
      errors++;
      $display("FAIL b2b_hold: addr=%02h wd=%08h, required 1f 04030201", addr, wr_data);
    end
  endtask

  initial begin
    reset   = 1'b1;
    tx_full = 1'b0;
    rd_data = 32'h0;
    rx_refresh();
    test_reset();
    test_write();
    test_read();
    test_backpressure();
    test_bad_cmd();
    test_reset_mid_write();
    test_timeout();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
